updown_direction_decoder: RTL
=============================

Name: updown_direction_decoder

Overview:
- Receive side of the up/down counter interface: watches a WIDTH-bit count value and recovers the `ud` direction that produced it, one step per clock.
- Also reports step and wrap events, declares lock after LOCK_LEN consecutive legal steps, and flags and counts illegal transitions.
- Placed downstream of an up/down counter (or its output bus) for direction readback and integrity checking.

Parameters:
WIDTH, 4, width of the observed count value
LOCK_LEN, 4, consecutive legal steps required to enter LOCKED (range 1..15)
ALLOW_HOLD, 0, 1: an unchanged value is a legal idle cycle; 0: an unchanged value is an error (the counter advances every clock)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
q_in  input  WIDTH  observed count value, sampled every rising edge
ud  output  1  direction of the last legal step; 1 = decrement, 0 = increment (same encoding as the counter's ud input)
step  output  1  one-cycle pulse: the last sample was a legal ±1 step
wrap  output  1  one-cycle pulse: the legal step wrapped (max→0 increment or 0→max decrement)
dir_change  output  1  one-cycle pulse: a legal step whose direction differs from the previous legal step
err  output  1  one-cycle pulse: illegal transition
locked  output  1  high while FSM is in LOCKED
err_cnt  output  ERR_W  number of err pulses since reset, saturating at all-ones

Behaviour:
- Reset (async, rst=1): state IDLE, prev_q=0, run=0, and every output 0. It takes effect immediately, including mid-lock. The first edge after release only captures q_in.
- Every edge: classify q_in against prev_q (mod 2^WIDTH), then set prev_q <= q_in.
  - UP: q_in == prev_q+1. Sets ud=0.
  - DOWN: q_in == prev_q-1. Sets ud=1.
  - HOLD: q_in == prev_q.
  - BAD: any other value.
- All outputs are registered. Events for the sample taken at edge N are visible from edge N until edge N+1 (pulses last exactly one cycle).
- step=1 on UP/DOWN.
- wrap=1 on UP from 2^WIDTH-1 to 0, or on DOWN from 0 to 2^WIDTH-1.
- dir_change=1 on UP/DOWN when the new ud differs from the held ud. It is suppressed on the first legal step after IDLE.
- ud holds its value on HOLD and BAD.
- err=1 on BAD, and on HOLD when ALLOW_HOLD=0. err_cnt increments on each err pulse and stops at all-ones.
- FSM (run = consecutive legal-step counter, 4 bits):
  - IDLE: next edge captures prev_q. Go to TRACK with run=0. No events.
  - TRACK:
    - UP/DOWN: run++. If run reaches LOCK_LEN, go to LOCKED and set locked=1 at that same edge.
    - HOLD with ALLOW_HOLD=1: no change.
    - Error: run=0, stay in TRACK.
  - LOCKED:
    - UP/DOWN (either direction, reversals legal): stay.
    - HOLD with ALLOW_HOLD=1: stay.
    - Error: go to TRACK, run=0, locked=0 at the same edge as err.
- Simultaneous wrap and dir_change are both reported (example: up to 15, then 15→0 is up with no change; 0→15 after an up step gives wrap and dir_change).
- run never exceeds LOCK_LEN.
- err_cnt is cleared only by rst.

Test Plan:
- Reset mid-run: during LOCKED with err_cnt=3, assert rst asynchronously between edges. All outputs read 0 before the next edge. After release, the first edge gives no step and no err.
- Lock-in increment (LOCK_LEN=4): q_in=5,6,7,8,9. step pulses on samples 6..9, ud=0 throughout. locked rises on the edge sampling 9, not before.
- Decrement with wrap: after lock, q_in=1,0,15,14. Expect ud=1 with dir_change on the first down step only. wrap=1 exactly on the 0→15 sample. step=1 on each sample.
- Reversal while locked: ...,7,8,9,8,7. dir_change=1 only on 9→8, ud goes 0→1, locked stays 1, err=0.
- Illegal jump: locked at 4, then q_in=9. err=1 for one cycle, locked=0, err_cnt +1, step=0, ud unchanged. Then 10,11,12,13 relocks on 13.
- Hold and saturation: ALLOW_HOLD=0, hold q_in=6 for 300 cycles. err pulses every cycle and err_cnt saturates at 255. Repeat with ALLOW_HOLD=1: no err, locked is kept.

Source files
------------

// File: rtl/updown_direction_decoder.sv
`default_nettype none
// ============================================================================
// Module  : updown_direction_decoder
// Purpose : Recovers the up/down direction from an observed count value and
//           reports step, wrap, reversal, lock and illegal-transition events.
// Revision: 1.0 - initial release
// ============================================================================
module updown_direction_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_LEN   = 4,
    parameter int ALLOW_HOLD = 0,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    output logic             ud,
    output logic             step,
    output logic             wrap,
    output logic             dir_change,
    output logic             err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_MAX      = '1;
    localparam logic [3:0]       C_RUN_ONE  = 4'd1;
    localparam logic [3:0]       C_LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [ERR_W-1:0] C_ERR_ONE  = ERR_W'(1);
    localparam logic             C_HOLD_OK  = (ALLOW_HOLD != 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_val_q, prev_val_d;
    logic [3:0]       run_q, run_d;
    logic             seen_step_q, seen_step_d;
    logic             ud_q, ud_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             dir_change_q, dir_change_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_up;
    logic             w_down;
    logic             w_hold;
    logic             w_bad;
    logic [3:0]       w_run_next;

    always_comb begin
        w_inc      = prev_val_q + C_ONE;
        w_dec      = prev_val_q - C_ONE;
        w_up       = (q_in == w_inc);
        // Up takes priority so a degenerate 1-bit counter still gets one direction.
        w_down     = (q_in == w_dec) && !w_up;
        w_hold     = (q_in == prev_val_q);
        w_bad      = !w_up && !w_down && !(w_hold && C_HOLD_OK);
        w_run_next = run_q + C_RUN_ONE;
    end

    always_comb begin
        state_d      = state_q;
        prev_val_d   = q_in;
        run_d        = run_q;
        seen_step_d  = seen_step_q;
        ud_d         = ud_q;
        step_d       = 1'b0;
        wrap_d       = 1'b0;
        dir_change_d = 1'b0;
        err_d        = 1'b0;
        locked_d     = locked_q;
        err_cnt_d    = err_cnt_q;

        if (state_q == S_IDLE) begin
            state_d  = S_TRACK;
            run_d    = 4'd0;
            locked_d = 1'b0;
        end else if (w_up || w_down) begin
            step_d       = 1'b1;
            ud_d         = w_down;
            wrap_d       = (w_up && (prev_val_q == C_MAX)) ||
                           (w_down && (prev_val_q == '0));
            // The very first legal step has no earlier direction to compare to.
            dir_change_d = seen_step_q && (w_down != ud_q);
            seen_step_d  = 1'b1;
            if (state_q == S_TRACK) begin
                run_d = w_run_next;
                if (w_run_next == C_LOCK_RUN) begin
                    state_d  = S_LOCKED;
                    locked_d = 1'b1;
                end
            end
        end else if (w_bad) begin
            err_d    = 1'b1;
            state_d  = S_TRACK;
            run_d    = 4'd0;
            locked_d = 1'b0;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + C_ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_val_q   <= '0;
            run_q        <= 4'd0;
            seen_step_q  <= 1'b0;
            ud_q         <= 1'b0;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            dir_change_q <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_val_q   <= prev_val_d;
            run_q        <= run_d;
            seen_step_q  <= seen_step_d;
            ud_q         <= ud_d;
            step_q       <= step_d;
            wrap_q       <= wrap_d;
            dir_change_q <= dir_change_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign ud         = ud_q;
    assign step       = step_q;
    assign wrap       = wrap_q;
    assign dir_change = dir_change_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire
